// File: rtl/rs_multi_cdb_if.sv
// Dispatcher / CDB / ALU-side bundle of the ALU reservation station.
// The master side drives the issue, CDB and out_ready signals. The slave side is the station.
interface rs_multi_cdb_if #(
  parameter int DEPTH   = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 3
);
  logic                      issue_valid;
  logic [OP_W-1:0]           issue_opcode;
  logic [ROB_W-1:0]          issue_rob_id;
  logic [DATA_W-1:0]         issue_vi, issue_vj;
  logic [ROB_W-1:0]          issue_qi, issue_qj;
  logic                      issue_ri, issue_rj;
  logic [DATA_W-1:0]         issue_imm, issue_pc;
  logic                      full;
  logic [$clog2(DEPTH):0]    count;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_id;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      out_valid, out_ready;
  logic [ROB_W-1:0]          out_rob_id;
  logic [OP_W-1:0]           out_opcode;
  logic [DATA_W-1:0]         out_val1, out_val2, out_imm, out_pc;

  modport master (
    output issue_valid, issue_opcode, issue_rob_id, issue_vi, issue_vj, issue_qi, issue_qj,
           issue_ri, issue_rj, issue_imm, issue_pc, cdb_valid, cdb_rob_id, cdb_data, out_ready,
    input  full, count, out_valid, out_rob_id, out_opcode, out_val1, out_val2, out_imm, out_pc
  );
  modport slave (
    input  issue_valid, issue_opcode, issue_rob_id, issue_vi, issue_vj, issue_qi, issue_qj,
           issue_ri, issue_rj, issue_imm, issue_pc, cdb_valid, cdb_rob_id, cdb_data, out_ready,
    output full, count, out_valid, out_rob_id, out_opcode, out_val1, out_val2, out_imm, out_pc
  );
endinterface

// File: rtl/rs_multi_cdb.sv
// Parameterised ALU reservation station. It snoops NUM_CDB broadcast channels and uses oldest-first select.
// An age matrix orders the busy entries. A registered dispatch stage uses a valid/ready handshake.
module rs_entry #(
  parameter int OP_W    = 6,
  parameter int ROB_W   = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      alloc,
  input  logic                      free,
  input  logic [OP_W-1:0]           issue_opcode,
  input  logic [ROB_W-1:0]          issue_rob_id,
  input  logic [1:0]                issue_r,
  input  logic [1:0][ROB_W-1:0]     issue_q,
  input  logic [1:0][DATA_W-1:0]    issue_v,
  input  logic [DATA_W-1:0]         issue_imm,
  input  logic [DATA_W-1:0]         issue_pc,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_id,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      busy,
  output logic                      ready,
  output logic [OP_W-1:0]           opcode,
  output logic [ROB_W-1:0]          rob_id,
  output logic [1:0][DATA_W-1:0]    v,
  output logic [DATA_W-1:0]         imm,
  output logic [DATA_W-1:0]         pc
);
  logic [1:0]             r, r_nxt, hit;
  logic [1:0][ROB_W-1:0]  q, q_nxt;
  logic [1:0][DATA_W-1:0] v_nxt, hit_data;

  // Issue bypass and wakeup are the same snoop, applied to either the incoming or the stored operand.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      r_nxt[k]    = alloc ? issue_r[k] : r[k];
      q_nxt[k]    = alloc ? issue_q[k] : q[k];
      v_nxt[k]    = alloc ? issue_v[k] : v[k];
      hit[k]      = 1'b0;
      hit_data[k] = '0;
      for (int c = 0; c < NUM_CDB; c++) begin
        if (!hit[k] && cdb_valid[c] && cdb_rob_id[c*ROB_W +: ROB_W] == q_nxt[k]) begin
          hit[k]      = 1'b1;
          hit_data[k] = cdb_data[c*DATA_W +: DATA_W];
        end
      end
      if (!r_nxt[k] && hit[k]) begin
        r_nxt[k] = 1'b1;
        q_nxt[k] = '0;
        v_nxt[k] = hit_data[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; r <= '0; q <= '0; v <= '0;
      opcode <= '0; rob_id <= '0; imm <= '0; pc <= '0;
    end else if (en) begin
      r <= r_nxt; q <= q_nxt; v <= v_nxt;
      if (alloc) begin
        busy <= 1'b1; opcode <= issue_opcode; rob_id <= issue_rob_id;
        imm <= issue_imm; pc <= issue_pc;
      end else if (free) begin
        busy <= 1'b0;
      end
    end
  end

  assign ready = busy & r[0] & r[1];
endmodule

module rs_multi_cdb #(
  parameter int DEPTH   = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clear,
  rs_multi_cdb_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic                              flush, issue_go, load, do_disp, found;
  logic [DEPTH-1:0]                  busy, ready, alloc, free, sel_oh, blocked;
  logic [DEPTH-1:0][DEPTH-1:0]       older;  // older[j][i]: entry j was issued before entry i
  logic [IW-1:0]                     sel_idx;
  logic [CW-1:0]                     count_nxt;
  logic [DEPTH-1:0][OP_W-1:0]        e_op;
  logic [DEPTH-1:0][ROB_W-1:0]       e_rob;
  logic [DEPTH-1:0][1:0][DATA_W-1:0] e_v;
  logic [DEPTH-1:0][DATA_W-1:0]      e_imm, e_pc;

  assign flush    = rst | clear;
  assign issue_go = bus.issue_valid & ~bus.full;
  assign load     = ~bus.out_valid | bus.out_ready;
  assign do_disp  = load & (|ready);
  assign free     = do_disp ? sel_oh : '0;

  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && !busy[i]) begin
        alloc[i] = issue_go;
        found    = 1'b1;
      end
    end
  end

  // Oldest ready entry: ready and no other ready entry is older than it.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older[j][i]) blocked[i] = 1'b1;
      if (ready[i] && !blocked[i]) begin
        sel_oh[i] = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      older <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc[i]) begin
          for (int j = 0; j < DEPTH; j++) begin
            older[i][j] <= 1'b0;
            older[j][i] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry #(.OP_W(OP_W), .ROB_W(ROB_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_ent (
      .clk(clk), .rst(flush), .en(rdy), .alloc(alloc[g]), .free(free[g]),
      .issue_opcode(bus.issue_opcode), .issue_rob_id(bus.issue_rob_id),
      .issue_r({bus.issue_rj, bus.issue_ri}), .issue_q({bus.issue_qj, bus.issue_qi}),
      .issue_v({bus.issue_vj, bus.issue_vi}), .issue_imm(bus.issue_imm), .issue_pc(bus.issue_pc),
      .cdb_valid(bus.cdb_valid), .cdb_rob_id(bus.cdb_rob_id), .cdb_data(bus.cdb_data),
      .busy(busy[g]), .ready(ready[g]), .opcode(e_op[g]), .rob_id(e_rob[g]),
      .v(e_v[g]), .imm(e_imm[g]), .pc(e_pc[g])
    );
  end

  assign count_nxt = bus.count + CW'(issue_go) - CW'(do_disp);

  always_ff @(posedge clk) begin
    if (flush) begin
      bus.out_valid <= 1'b0; bus.out_rob_id <= '0; bus.out_opcode <= '0;
      bus.out_val1 <= '0; bus.out_val2 <= '0; bus.out_imm <= '0; bus.out_pc <= '0;
      bus.count <= '0; bus.full <= 1'b0;
    end else if (rdy) begin
      bus.count <= count_nxt;
      bus.full  <= (count_nxt == CW'(DEPTH));
      if (load) begin
        bus.out_valid <= |ready;
        if (|ready) begin
          bus.out_rob_id <= e_rob[sel_idx]; bus.out_opcode <= e_op[sel_idx];
          bus.out_val1 <= e_v[sel_idx][0]; bus.out_val2 <= e_v[sel_idx][1];
          bus.out_imm <= e_imm[sel_idx]; bus.out_pc <= e_pc[sel_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Scoreboard bench for rs_multi_cdb: expected dispatches are queued at issue time.
// The monitor pops and compares them on each accepted handshake.
module tb_rs_multi_cdb;
  localparam int DEPTH = 16, ROB_W = 4, OP_W = 6, DATA_W = 32, NUM_CDB = 3;

  logic clk = 1'b0;
  logic rst, rdy, clear;

  rs_multi_cdb_if #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) bus();
  rs_multi_cdb #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROB_W-1:0]  rob;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1, v2, imm, pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [OP_W-1:0] op_of(input logic [ROB_W-1:0] rob);
    return OP_W'({2'b10, rob});
  endfunction
  function automatic logic [DATA_W-1:0] imm_of(input logic [ROB_W-1:0] rob);
    return 32'h1000 + DATA_W'(rob);
  endfunction
  function automatic logic [DATA_W-1:0] pc_of(input logic [ROB_W-1:0] rob);
    return 32'h8000 + DATA_W'({rob, 2'b00});
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic set_issue(input logic [ROB_W-1:0] rob, input logic ri, input logic [DATA_W-1:0] vi,
                           input logic [ROB_W-1:0] qi, input logic rj, input logic [DATA_W-1:0] vj,
                           input logic [ROB_W-1:0] qj);
    bus.issue_valid = 1'b1; bus.issue_rob_id = rob; bus.issue_opcode = op_of(rob);
    bus.issue_ri = ri; bus.issue_vi = vi; bus.issue_qi = qi;
    bus.issue_rj = rj; bus.issue_vj = vj; bus.issue_qj = qj;
    bus.issue_imm = imm_of(rob); bus.issue_pc = pc_of(rob);
  endtask

  task automatic push(input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    exp_t e;
    e.rob = rob; e.op = op_of(rob); e.v1 = v1; e.v2 = v2; e.imm = imm_of(rob); e.pc = pc_of(rob);
    exp_q.push_back(e);
  endtask

  task automatic drive_cdb(input int ch, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] d);
    bus.cdb_valid[ch] = 1'b1;
    bus.cdb_rob_id[ch*ROB_W +: ROB_W] = tag;
    bus.cdb_data[ch*DATA_W +: DATA_W] = d;
  endtask

  // A handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && !clear && rdy && bus.out_valid && bus.out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dispatch: got rob %0d val1 %h, expected nothing", bus.out_rob_id, bus.out_val1);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.out_rob_id !== mon_e.rob || bus.out_opcode !== mon_e.op || bus.out_val1 !== mon_e.v1 ||
            bus.out_val2 !== mon_e.v2 || bus.out_imm !== mon_e.imm || bus.out_pc !== mon_e.pc) begin
          n_fail++;
          $display("FAIL dispatch_order: got rob %0d op %h v1 %h v2 %h imm %h pc %h, want rob %0d op %h v1 %h v2 %h imm %h pc %h",
                   bus.out_rob_id, bus.out_opcode, bus.out_val1, bus.out_val2, bus.out_imm, bus.out_pc,
                   mon_e.rob, mon_e.op, mon_e.v1, mon_e.v2, mon_e.imm, mon_e.pc);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_opcode = '0; bus.issue_rob_id = '0;
    bus.issue_vi = '0; bus.issue_vj = '0; bus.issue_qi = '0; bus.issue_qj = '0;
    bus.issue_ri = 1'b0; bus.issue_rj = 1'b0; bus.issue_imm = '0; bus.issue_pc = '0;
    bus.cdb_valid = '0; bus.cdb_rob_id = '0; bus.cdb_data = '0; bus.out_ready = 1'b1;
    step; step;
    rst = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_chk++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_chk++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_chk++; if (bus.out_rob_id !== 4'd0 || bus.out_val1 !== 32'd0) begin n_fail++; $display("FAIL reset_out_fields: got rob %0d val1 %h want 0 0", bus.out_rob_id, bus.out_val1); end
    set_issue(4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    push(4'd3, 32'd5, 32'd7);
    step;
    bus.issue_valid = 1'b0;
    n_chk++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL first_count_c2: got %0d want 1", bus.count); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid_c2: got %b want 0", bus.out_valid); end
    step;
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid_c3: got %b want 1", bus.out_valid); end
    n_chk++; if (bus.out_rob_id !== 4'd3 || bus.out_val1 !== 32'd5 || bus.out_val2 !== 32'd7) begin
      n_fail++; $display("FAIL first_fields_c3: got rob %0d v1 %0d v2 %0d want 3 5 7", bus.out_rob_id, bus.out_val1, bus.out_val2); end
    n_chk++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL first_count_c3: got %0d want 0", bus.count); end
    step;
  endtask

  task automatic test_age;
    bus.out_ready = 1'b1;
    // Younger ready B overtakes older pending A.
    push(4'd2, 32'h30, 32'h31);
    push(4'd1, 32'h99, 32'h21);
    set_issue(4'd1, 1'b0, 32'hDEAD, 4'd9, 1'b1, 32'h21, 4'd0); step;
    set_issue(4'd2, 1'b1, 32'h30, 4'd0, 1'b1, 32'h31, 4'd0); step;
    bus.issue_valid = 1'b0; drive_cdb(0, 4'd9, 32'h99); step;
    bus.cdb_valid = '0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL age_pending_drain: %0d left want 0", exp_q.size()); end
    // Y,Z in entries 1,2; W reuses entry 0 but is youngest; all wake together.
    push(4'd6, 32'hC8, 32'h61);
    push(4'd7, 32'hC7, 32'h71);
    push(4'd8, 32'hC7, 32'h81);
    push(4'd9, 32'hC7, 32'h91);
    set_issue(4'd6, 1'b0, 32'h0, 4'd8, 1'b1, 32'h61, 4'd0); step;
    set_issue(4'd7, 1'b0, 32'h0, 4'd7, 1'b1, 32'h71, 4'd0); step;
    set_issue(4'd8, 1'b0, 32'h0, 4'd7, 1'b1, 32'h81, 4'd0); step;
    bus.issue_valid = 1'b0; drive_cdb(1, 4'd8, 32'hC8); step;
    bus.cdb_valid = '0; step; step;
    set_issue(4'd9, 1'b0, 32'h0, 4'd7, 1'b1, 32'h91, 4'd0); step;
    bus.issue_valid = 1'b0; step;
    drive_cdb(0, 4'd7, 32'hC7); step;
    bus.cdb_valid = '0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL age_same_cycle_drain: %0d left want 0", exp_q.size()); end
    n_chk++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL age_count_empty: got %0d want 0", bus.count); end
  endtask

  task automatic test_bypass;
    bus.out_ready = 1'b1;
    set_issue(4'd10, 1'b1, 32'h10, 4'd0, 1'b0, 32'h0, 4'd5);
    drive_cdb(2, 4'd5, 32'hAA);
    push(4'd10, 32'h10, 32'hAA);
    step;
    bus.issue_valid = 1'b0; bus.cdb_valid = '0;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_early: got out_valid %b want 0", bus.out_valid); end
    step;
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_val2 !== 32'hAA || bus.out_rob_id !== 4'd10) begin
      n_fail++; $display("FAIL bypass_dispatch: got valid %b rob %0d v2 %h want 1 10 aa", bus.out_valid, bus.out_rob_id, bus.out_val2); end
    step;
    // Wakeup with two channels matching: channel 0 wins.
    set_issue(4'd11, 1'b1, 32'h12, 4'd0, 1'b0, 32'h0, 4'd6);
    push(4'd11, 32'h12, 32'h11);
    step;
    bus.issue_valid = 1'b0;
    drive_cdb(0, 4'd6, 32'h11); drive_cdb(1, 4'd6, 32'h22); step;
    bus.cdb_valid = '0;
    // Issue bypass with two channels matching: channel 1 beats channel 2.
    set_issue(4'd12, 1'b0, 32'h0, 4'd4, 1'b1, 32'h13, 4'd0);
    drive_cdb(1, 4'd4, 32'h44); drive_cdb(2, 4'd4, 32'h55);
    push(4'd12, 32'h44, 32'h13);
    step;
    bus.issue_valid = 1'b0; bus.cdb_valid = '0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bypass_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_full;
    bus.out_ready = 1'b0;
    // First instruction moves straight into the dispatch register; the next DEPTH fill the station.
    for (int k = 0; k <= DEPTH; k++) begin
      set_issue(4'(k), 1'b1, 32'(256 + k), 4'd0, 1'b1, 32'(512 + k), 4'd0);
      push(4'(k), 32'(256 + k), 32'(512 + k));
      step;
    end
    n_chk++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", bus.full); end
    n_chk++; if (bus.count !== 5'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", bus.count, DEPTH); end
    set_issue(4'd15, 1'b1, 32'h3FF, 4'd0, 1'b1, 32'h3FF, 4'd0);
    step;
    bus.issue_valid = 1'b0;
    n_chk++; if (bus.count !== 5'(DEPTH) || bus.full !== 1'b1) begin
      n_fail++; $display("FAIL full_drop: got count %0d full %b want %0d 1", bus.count, bus.full, DEPTH); end
    for (int c = 0; c < 5; c++) begin
      step;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rob_id !== 4'd0 || bus.out_val1 !== 32'h100 || bus.out_val2 !== 32'h200) begin
        n_fail++; $display("FAIL backpressure_hold: got valid %b rob %0d v1 %h v2 %h want 1 0 100 200",
                           bus.out_valid, bus.out_rob_id, bus.out_val1, bus.out_val2); end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step;
      n_chk++; if (bus.count !== 5'(DEPTH - 1 - i)) begin
        n_fail++; $display("FAIL drain_rate: got count %0d want %0d", bus.count, DEPTH - 1 - i); end
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step;
    n_chk++; if (exp_q.size() != 0 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL full_drain: got %0d left full %b want 0 0", exp_q.size(), bus.full); end
  endtask

  task automatic test_stall;
    bus.out_ready = 1'b1;
    rdy = 1'b0;
    set_issue(4'd13, 1'b1, 32'h600, 4'd0, 1'b1, 32'h601, 4'd0);
    repeat (3) step;
    bus.issue_valid = 1'b0; rdy = 1'b1;
    n_chk++; if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_no_issue: got count %0d valid %b want 0 0", bus.count, bus.out_valid); end
    bus.out_ready = 1'b0;
    set_issue(4'd14, 1'b1, 32'h700, 4'd0, 1'b1, 32'h701, 4'd0);
    push(4'd14, 32'h700, 32'h701);
    step;
    bus.issue_valid = 1'b0;
    step;
    rdy = 1'b0; bus.out_ready = 1'b1;
    repeat (3) step;
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rob_id !== 4'd14 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL stall_hold: got valid %b rob %0d queued %0d want 1 14 1", bus.out_valid, bus.out_rob_id, exp_q.size()); end
    rdy = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step;
    step;
    n_chk++; if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got %0d left valid %b want 0 0", exp_q.size(), bus.out_valid); end
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_issue(4'(k), (k % 2 == 0), 32'(768 + k), 4'd13, 1'b1, 32'(1024 + k), 4'd0);
      step;
    end
    bus.issue_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b1 || bus.count !== 5'd5) begin
      n_fail++; $display("FAIL flush_setup: got valid %b count %0d want 1 5", bus.out_valid, bus.count); end
    bus.out_ready = 1'b1; clear = 1'b1;
    step;
    clear = 1'b0;
    exp_q.delete();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.count !== 5'd0 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got valid %b count %0d full %b want 0 0 0", bus.out_valid, bus.count, bus.full); end
    n_chk++; if (bus.out_rob_id !== 4'd0 || bus.out_val1 !== 32'd0 || bus.out_val2 !== 32'd0) begin
      n_fail++; $display("FAIL flush_fields: got rob %0d v1 %h v2 %h want 0 0 0", bus.out_rob_id, bus.out_val1, bus.out_val2); end
    drive_cdb(0, 4'd13, 32'hDD); step;
    bus.cdb_valid = '0;
    for (int i = 0; i < 3; i++) begin
      step;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_cdb: got valid %b want 0", bus.out_valid); end
    end
    set_issue(4'd12, 1'b1, 32'h500, 4'd0, 1'b1, 32'h501, 4'd0);
    push(4'd12, 32'h500, 32'h501);
    step;
    bus.issue_valid = 1'b0;
    n_chk++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL flush_reissue_count: got %0d want 1", bus.count); end
    step;
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rob_id !== 4'd12) begin
      n_fail++; $display("FAIL flush_reissue: got valid %b rob %0d want 1 12", bus.out_valid, bus.out_rob_id); end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_drain: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_age;
    test_bypass;
    test_full;
    test_stall;
    test_flush;
    repeat (3) step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
